// File: rtl/key_event_decoder.sv
// Turns the debounced key level into one-cycle event strobes:
// press, release, short, long and auto-repeat while held.
module key_event_decoder #(
    parameter int LONG_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       rst_a_p,
    input  logic       key_in,
    input  logic       enable,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       short_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] event_count
);

    localparam int MAX_CYCLES =
        (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        LONG_HELD
    } state_t;

    state_t           state_q;
    logic             key_d_q;
    logic [CNT_W-1:0] timer_q;
    logic             press_q;
    logic             release_q;
    logic             short_q;
    logic             long_q;
    logic             repeat_q;
    logic             held_q;
    logic [7:0]       count_q;

    logic rise;
    assign rise = key_in & ~key_d_q;

    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            state_q   <= IDLE;
            key_d_q   <= 1'b0;
            timer_q   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            key_d_q   <= key_in;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            // Disabling abandons any press silently; the count is kept.
            if (!enable) begin
                state_q <= IDLE;
                timer_q <= '0;
                held_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_q <= PRESSED;
                            timer_q <= '0;
                            press_q <= 1'b1;
                            held_q  <= 1'b1;
                            count_q <= count_q + 8'd1;
                        end
                    end
                    PRESSED: begin
                        if (!key_in) begin
                            state_q   <= IDLE;
                            short_q   <= 1'b1;
                            release_q <= 1'b1;
                            held_q    <= 1'b0;
                        end else if (timer_q == LONG_LAST) begin
                            state_q <= LONG_HELD;
                            timer_q <= '0;
                            long_q  <= 1'b1;
                        end else begin
                            timer_q <= timer_q + CNT_W'(1);
                        end
                    end
                    LONG_HELD: begin
                        if (!key_in) begin
                            state_q   <= IDLE;
                            release_q <= 1'b1;
                            held_q    <= 1'b0;
                        end else if (timer_q == REPEAT_LAST) begin
                            repeat_q <= 1'b1;
                            timer_q  <= '0;
                        end else begin
                            timer_q <= timer_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        timer_q <= '0;
                        held_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;
    assign event_count   = count_q;

endmodule
